modulo_comparador_serial: RTL and testbench

MODULO_COMPARADOR_SERIAL -- requirements
Module: modulo_comparador_serial

---
 rtl/modulo_comparador_serial.sv | 143 ++++++++++++++
 tb/tb_modulo_comparador_serial.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/modulo_comparador_serial.sv
// Serial magnitude comparator: walks the operands MSB first, one bit pair per cycle,
// and reports A<B / A=B / A>B together with the number of bits examined.
module modulo_comparador_serial #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [WIDTH-1:0]           A,
  input  logic [WIDTH-1:0]           B,
  output logic                       busy,
  output logic                       done,
  output logic                       AltB_out,
  output logic                       AeqB_out,
  output logic                       AgtB_out,
  output logic [$clog2(WIDTH+1)-1:0] ciclos
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, COMPARA, FIM} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic            r_signed;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;
  logic            r_found;
  logic            r_found_gt;
  logic            r_lt;
  logic            r_eq;
  logic            r_gt;
  logic [CW-1:0]   r_ciclos;

  logic w_bit_a;
  logic w_bit_b;
  logic w_diff;
  logic w_a_gt;
  logic w_last;
  logic w_res_lt;
  logic w_res_eq;
  logic w_res_gt;

  always_comb begin
    w_bit_a = r_a[r_idx];
    w_bit_b = r_b[r_idx];
    w_diff  = w_bit_a ^ w_bit_b;
    // In signed mode the MSB is the sign bit, so a set bit in A makes A smaller.
    w_a_gt  = w_bit_a ^ (r_signed && (r_idx == IW'(WIDTH - 1)));
    w_last  = (r_idx == '0);

    w_res_lt = 1'b0;
    w_res_eq = 1'b0;
    w_res_gt = 1'b0;
    if (r_found) begin
      w_res_gt = r_found_gt;
      w_res_lt = ~r_found_gt;
    end else if (w_diff) begin
      w_res_gt = w_a_gt;
      w_res_lt = ~w_a_gt;
    end else begin
      w_res_eq = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_next = COMPARA;
      end
      COMPARA: begin
        if ((EARLY_EXIT != 0) && w_diff) w_next = FIM;
        else if (w_last)                 w_next = FIM;
      end
      FIM:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_signed   <= 1'b0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_found    <= 1'b0;
      r_found_gt <= 1'b0;
      r_lt       <= 1'b0;
      r_eq       <= 1'b0;
      r_gt       <= 1'b0;
      r_ciclos   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a        <= A;
            r_b        <= B;
            r_signed   <= signed_mode;
            r_idx      <= IW'(WIDTH - 1);
            r_cnt      <= '0;
            r_found    <= 1'b0;
            r_found_gt <= 1'b0;
          end
        end
        COMPARA: begin
          r_cnt <= r_cnt + CW'(1);
          if (!w_last) r_idx <= r_idx - IW'(1);
          if (!r_found && w_diff) begin
            r_found    <= 1'b1;
            r_found_gt <= w_a_gt;
          end
          if (w_next == FIM) begin
            r_lt     <= w_res_lt;
            r_eq     <= w_res_eq;
            r_gt     <= w_res_gt;
            r_ciclos <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = (r_state == FIM);
  assign AltB_out = r_lt;
  assign AeqB_out = r_eq;
  assign AgtB_out = r_gt;
  assign ciclos   = r_ciclos;

endmodule

// File: tb/tb_modulo_comparador_serial.sv
// Scoreboard bench: an early-exit and a full-scan comparator instance share operands;
// expected results are queued at stimulus time and popped by a done-driven monitor.
module tb_modulo_comparador_serial;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       signed_mode = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;

  logic       busy0, done0, lt0, eq0, gt0;
  logic       busy1, done1, lt1, eq1, gt1;
  logic [3:0] cic0, cic1;

  always #5 clk = ~clk;

  modulo_comparador_serial #(.WIDTH(8), .EARLY_EXIT(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .signed_mode(signed_mode),
    .A(A), .B(B), .busy(busy0), .done(done0),
    .AltB_out(lt0), .AeqB_out(eq0), .AgtB_out(gt0), .ciclos(cic0)
  );

  modulo_comparador_serial #(.WIDTH(8), .EARLY_EXIT(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .signed_mode(signed_mode),
    .A(A), .B(B), .busy(busy1), .done(done1),
    .AltB_out(lt1), .AeqB_out(eq1), .AgtB_out(gt1), .ciclos(cic1)
  );

  typedef struct {
    logic [2:0]  flags;   // {lt, eq, gt}
    int unsigned c;
    int unsigned cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one pop per done pulse; a pulse with nothing queued is itself an error.
  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) check("dut0_unexpected_done", 1, 0);
      else begin
        e = q0.pop_front();
        check("dut0_flags", int'({lt0, eq0, gt0}), int'(e.flags));
        check("dut0_ciclos", int'(cic0), int'(e.c));
        check("dut0_latency", int'(cyc), int'(e.cyc));
      end
    end
    if (done1) begin
      if (q1.size() == 0) check("dut1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        check("dut1_flags", int'({lt1, eq1, gt1}), int'(e.flags));
        check("dut1_ciclos", int'(cic1), int'(e.c));
        check("dut1_latency", int'(cyc), int'(e.cyc));
      end
    end
  end

  // One comparison on DUT sel; k is the expected number of bits examined.
  // When chg is set, B is overwritten mid-run with newb.
  task automatic run(input int sel, input logic [7:0] a, input logic [7:0] b,
                     input logic sm, input logic [2:0] flags, input int unsigned k,
                     input logic chg, input logic [7:0] newb);
    exp_t e;
    int   cnt;
    @(negedge clk);
    A = a; B = b; signed_mode = sm;
    e.flags = flags; e.c = k; e.cyc = cyc + 1 + k;
    if (sel == 0) begin q0.push_back(e); start0 = 1'b1; end
    else          begin q1.push_back(e); start1 = 1'b1; end
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    cnt = 0;
    for (int g = 0; g < 64; g++) begin
      if (!((sel == 0) ? busy0 : busy1)) break;
      cnt++;
      if (chg && cnt == 3) B = newb;
      @(negedge clk);
    end
    check((sel == 0) ? "dut0_busy_cycles" : "dut1_busy_cycles", cnt, int'(k) + 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned s;
    int          cnt;
    repeat (3) @(negedge clk);
    check("rst_busy0", int'(busy0), 0);
    check("rst_done0", int'(done0), 0);
    check("rst_flags0", int'({lt0, eq0, gt0}), 0);
    check("rst_ciclos0", int'(cic0), 0);
    check("rst_flags1", int'({lt1, eq1, gt1}), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_flags0", int'({lt0, eq0, gt0}), 0);

    // flags encoding {lt, eq, gt}
    run(0, 8'h80, 8'h7F, 1'b0, 3'b001, 1, 1'b0, 8'h00);
    run(0, 8'h80, 8'h7F, 1'b1, 3'b100, 1, 1'b0, 8'h00);
    run(0, 8'h03, 8'h05, 1'b0, 3'b100, 6, 1'b0, 8'h00);
    run(0, 8'hA5, 8'hA5, 1'b0, 3'b010, 8, 1'b0, 8'h00);
    run(0, 8'hA5, 8'hA5, 1'b1, 3'b010, 8, 1'b0, 8'h00);
    run(0, 8'hFF, 8'h01, 1'b1, 3'b100, 1, 1'b0, 8'h00);
    run(0, 8'hFE, 8'hFF, 1'b1, 3'b100, 8, 1'b0, 8'h00);
    run(0, 8'h7F, 8'h01, 1'b1, 3'b001, 2, 1'b0, 8'h00);
    run(0, 8'h01, 8'h00, 1'b0, 3'b001, 8, 1'b0, 8'h00);

    run(1, 8'h80, 8'h7F, 1'b0, 3'b001, 8, 1'b1, 8'hFF);
    run(1, 8'h03, 8'h05, 1'b0, 3'b100, 8, 1'b0, 8'h00);
    run(1, 8'h5A, 8'h5A, 1'b1, 3'b010, 8, 1'b0, 8'h00);

    // Back-to-back: start held high restarts in the first IDLE cycle after FIM.
    @(negedge clk);
    A = 8'h10; B = 8'h20; signed_mode = 1'b0;
    s = cyc + 1;
    q0.push_back('{flags: 3'b100, c: 3, cyc: s + 3});
    q0.push_back('{flags: 3'b100, c: 3, cyc: s + 8});
    start0 = 1'b1;
    while (cyc < s + 6) @(negedge clk);
    start0 = 1'b0;
    cnt = 0;
    for (int g = 0; g < 20 && busy0; g++) begin cnt++; @(negedge clk); end
    check("b2b_finished", int'(busy0), 0);
    check("b2b_queue_drained", q0.size(), 0);

    // Abort: start pulsed while busy, then reset on the third COMPARA cycle.
    @(negedge clk);
    A = 8'h03; B = 8'h05; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    check("abort_busy_before", int'(busy0), 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy0), 0);
    check("abort_done", int'(done0), 0);
    check("abort_flags0", int'({lt0, eq0, gt0}), 0);
    check("abort_ciclos0", int'(cic0), 0);
    check("abort_flags1", int'({lt1, eq1, gt1}), 0);
    check("abort_ciclos1", int'(cic1), 0);
    reset_n = 1'b1;
    cnt = 0;
    for (int g = 0; g < 12; g++) begin
      @(negedge clk);
      if (busy0) cnt++;
    end
    check("abort_no_rerun", cnt, 0);

    run(0, 8'h40, 8'h41, 1'b0, 3'b100, 8, 1'b0, 8'h00);

    repeat (3) @(negedge clk);
    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
